// File: rtl/seg_share_arbiter.sv
// Shares a 4-digit seven-segment display between three requesters with hold time and blank-on-switch.
// Optional macro SEG_ROUND_ROBIN_EN replaces fixed priority/preemption with circular hand-over.
module seg_share_arbiter #(
  parameter int         REFRESH_DIV = 200000,
  parameter int         HOLD_MIN    = 50000000,
  parameter logic [7:0] BLANK_CHAR  = 8'b00000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  req,
  input  logic [31:0] glyph0,
  input  logic [31:0] glyph1,
  input  logic [31:0] glyph2,
  output logic [2:0]  grant,
  output logic [7:0]  seg,
  output logic [3:0]  an,
  output logic        busy
);

  localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int HW = $clog2(HOLD_MIN + 1);
  localparam logic [RW-1:0] REF_LAST  = RW'(REFRESH_DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_MIN - 1);
  localparam logic [HW-1:0] HOLD_SAT  = HW'(HOLD_MIN);

  typedef enum logic [1:0] {IDLE, BLANK, OWN} state_t;

  state_t        state;
  logic [RW-1:0] ref_cnt;
  logic [1:0]    digit;
  logic [HW-1:0] hold_cnt;

  logic [2:0]  idle_pick;
  logic [2:0]  nxt_owner;
  logic        do_switch;
  logic        go_idle;
  logic        hold_done;
  logic        ref_wrap;
  logic [1:0]  digit_n;
  logic [31:0] sel_word;

  // Lowest set bit is the highest-priority requester.
  function automatic logic [2:0] pick_fixed(input logic [2:0] r);
    return r & (3'(~r) + 3'd1);
  endfunction

`ifdef SEG_ROUND_ROBIN_EN
  logic [2:0] last_owner;

  // First requester in circular order strictly after cur (cur itself is checked last).
  function automatic logic [2:0] pick_after(input logic [2:0] r, input logic [2:0] cur);
    logic [2:0] res;
    int         base;
    res  = 3'b000;
    base = cur[0] ? 0 : (cur[1] ? 1 : 2);
    for (int k = 3; k >= 1; k--) begin
      if (r[(base + k) % 3]) res = 3'(1 << ((base + k) % 3));
    end
    return res;
  endfunction
`endif

  always_comb begin
    hold_done = (hold_cnt == HOLD_LAST) || (hold_cnt == HOLD_SAT);
    ref_wrap  = (ref_cnt == REF_LAST);
    digit_n   = ref_wrap ? digit + 2'd1 : digit;
    sel_word  = grant[0] ? glyph0 : (grant[1] ? glyph1 : glyph2);
    nxt_owner = grant;
    do_switch = 1'b0;
    go_idle   = 1'b0;
`ifdef SEG_ROUND_ROBIN_EN
    idle_pick = pick_after(req, last_owner);
    if (state == OWN && hold_done) begin
      if (|(req & ~grant)) begin
        nxt_owner = pick_after(req & ~grant, grant);
        do_switch = 1'b1;
      end else if (!(|(req & grant))) begin
        go_idle = 1'b1;
      end
    end
`else
    idle_pick = pick_fixed(req);
    if (state == OWN && hold_done) begin
      if (|(req & 3'(grant - 3'd1))) begin
        nxt_owner = pick_fixed(req & 3'(grant - 3'd1));
        do_switch = 1'b1;
      end else if (!(|(req & grant))) begin
        if (|req) begin
          nxt_owner = pick_fixed(req);
          do_switch = 1'b1;
        end else begin
          go_idle = 1'b1;
        end
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      grant    <= 3'b000;
      seg      <= BLANK_CHAR;
      an       <= 4'b0000;
      busy     <= 1'b0;
      ref_cnt  <= '0;
      digit    <= 2'd0;
      hold_cnt <= '0;
`ifdef SEG_ROUND_ROBIN_EN
      last_owner <= 3'b100;
`endif
    end else begin
      case (state)
        IDLE: begin
          an  <= 4'b0000;
          seg <= BLANK_CHAR;
          if (|req) begin
            grant   <= idle_pick;
            state   <= BLANK;
            busy    <= 1'b1;
            ref_cnt <= '0;
`ifdef SEG_ROUND_ROBIN_EN
            last_owner <= idle_pick;
`endif
          end
        end
        BLANK: begin
          if (ref_wrap) begin
            state    <= OWN;
            ref_cnt  <= '0;
            digit    <= 2'd0;
            hold_cnt <= '0;
            an       <= 4'b0001;
            seg      <= sel_word[7:0];
          end else begin
            ref_cnt <= ref_cnt + 1'b1;
          end
        end
        OWN: begin
          if (do_switch) begin
            state   <= BLANK;
            grant   <= nxt_owner;
            an      <= 4'b0000;
            seg     <= BLANK_CHAR;
            ref_cnt <= '0;
`ifdef SEG_ROUND_ROBIN_EN
            last_owner <= nxt_owner;
`endif
          end else if (go_idle) begin
            state <= IDLE;
            grant <= 3'b000;
            an    <= 4'b0000;
            seg   <= BLANK_CHAR;
            busy  <= 1'b0;
          end else begin
            if (hold_cnt != HOLD_SAT) hold_cnt <= hold_cnt + 1'b1;
            ref_cnt <= ref_wrap ? '0 : ref_cnt + 1'b1;
            digit   <= digit_n;
            // Glyph is taken live so content updates appear without re-arbitration.
            an      <= 4'(4'b0001 << digit_n);
            seg     <= sel_word[{digit_n, 3'b000} +: 8];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seg_share_arbiter.sv
// Randomized bench for seg_share_arbiter against an ownership-timeline reference model.
module tb_seg_share_arbiter;

  localparam int R    = 4;
  localparam int HOLD = 20;
  localparam logic [7:0] BLANK = 8'h00;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req;
  logic [31:0] glyph0, glyph1, glyph2;
  logic [2:0]  grant;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: phase 0 idle, 1 blank, 2 own; m_cnt = cycles elapsed in phase.
  int         m_phase, m_owner, m_last, m_cnt;
  logic [7:0] m_seg;

  seg_share_arbiter #(.REFRESH_DIV(R), .HOLD_MIN(HOLD), .BLANK_CHAR(BLANK)) dut (
    .clk(clk), .reset(reset), .req(req),
    .glyph0(glyph0), .glyph1(glyph1), .glyph2(glyph2),
    .grant(grant), .seg(seg), .an(an), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] glyph_of(input int o);
    return (o == 0) ? glyph0 : ((o == 1) ? glyph1 : glyph2);
  endfunction

  function automatic int idle_choice(input logic [2:0] r);
`ifdef SEG_ROUND_ROBIN_EN
    for (int k = 1; k <= 3; k++) if (r[(m_last + k) % 3]) return (m_last + k) % 3;
`else
    for (int i = 0; i < 3; i++) if (r[i]) return i;
`endif
    return -1;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_owner = -1; m_last = 2; m_cnt = 0; m_seg = BLANK;
  endtask

  task automatic grant_to(input int o);
    m_owner = o; m_last = o; m_phase = 1; m_cnt = 0;
  endtask

  task automatic model_step();
    int  sw;
    bit  stay;
    sw = -1; stay = 1'b1;
    case (m_phase)
      0: if (req != 3'b000) grant_to(idle_choice(req));
      1: if (m_cnt == R - 1) begin m_phase = 2; m_cnt = 0; end else m_cnt++;
      default: begin
        if (m_cnt + 1 >= HOLD) begin
`ifdef SEG_ROUND_ROBIN_EN
          for (int k = 2; k >= 1; k--) if (req[(m_owner + k) % 3]) sw = (m_owner + k) % 3;
`else
          for (int i = m_owner - 1; i >= 0; i--) if (req[i]) sw = i;
          if (sw < 0 && !req[m_owner])
            for (int i = 2; i >= 0; i--) if (req[i]) sw = i;
`endif
          if (sw >= 0) begin grant_to(sw); stay = 1'b0; end
          else if (!req[m_owner]) begin m_phase = 0; m_owner = -1; stay = 1'b0; end
        end
        if (stay) m_cnt++;
      end
    endcase
    m_seg = (m_phase == 2) ? 8'((glyph_of(m_owner) >> (8 * ((m_cnt / R) % 4))) & 32'hFF) : BLANK;
  endtask

  task automatic check_outputs();
    logic [2:0] eg;
    logic [3:0] ea;
    eg = (m_phase == 0) ? 3'b000 : 3'(1 << m_owner);
    ea = (m_phase == 2) ? 4'(1 << ((m_cnt / R) % 4)) : 4'b0000;
    chk("grant", 32'(grant), 32'(eg));
    chk("an", 32'(an), 32'(ea));
    chk("seg", 32'(seg), 32'(m_seg));
    chk("busy", 32'(busy), 32'(m_phase != 0));
    chk("onehot", 32'($onehot0(grant)), 32'd1);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_lit(input logic [2:0] g, input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 120 && !ok; i++) begin
      tick();
      if (grant == g && an == 4'b0001) ok = 1'b1;
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  initial begin
    int  n;
    bit  found;
    reset = 1'b1; req = 3'b000;
    glyph0 = 32'hA3B2C1D0; glyph1 = 32'h44332211; glyph2 = 32'h0F1E2D3C;
    model_reset();
    @(negedge clk); @(negedge clk);
    check_outputs();
    reset = 1'b0;

    // First ownership from idle: grant after one cycle, first lit digit after REFRESH_DIV+1.
    req = 3'b010;
    n = 0; found = 1'b0;
    while (!found && n < 50) begin
      tick();
      n++;
      if (n == 1) chk("grant_lat", 32'(grant), 32'h2);
      if (an == 4'b0001) found = 1'b1;
    end
    chk("first_lit", 32'(n), 32'(R + 1));
    chk("first_seg", 32'(seg), 32'h11);

    // Higher priority arrives early in the hold window.
    ticks(5);
    req = 3'b011;
    wait_lit(3'b001, "preempt");

    // Owner 0 drops its request early; it keeps the display until hold expires.
    ticks(3);
    req = 3'b010;
    ticks(10);
    chk("hold_keep", 32'(grant), 32'h1);
    wait_lit(3'b010, "handover");

    // Move to requester 2, then let it go idle and re-arbitrate all three at once.
    req = 3'b100;
    wait_lit(3'b100, "to_owner2");
    ticks(HOLD + 2);
    req = 3'b000;
    tick();
    chk("idle_grant", 32'(grant), 32'h0);
    chk("idle_busy", 32'(busy), 32'h0);
    req = 3'b111;
    tick();
    chk("all_req_grant", 32'(grant), 32'h1);
    ticks(100);

    // Asynchronous reset in the middle of a scan.
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      tick();
      if (an == 4'b0100) found = 1'b1;
    end
    chk("wait_an2", 32'(found), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_an", 32'(an), 32'h0);
    chk("rst_seg", 32'(seg), 32'(BLANK));
    chk("rst_busy", 32'(busy), 32'h0);
    @(negedge clk);
    reset = 1'b0; req = 3'b000;
    model_reset();

    // Random requests with sticky bits and live glyph updates.
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < 3; b++) if ($urandom_range(15) == 0) req[b] = ~req[b];
      if ($urandom_range(7) == 0) begin
        case ($urandom_range(2))
          0: glyph0 = $urandom;
          1: glyph1 = $urandom;
          default: glyph2 = $urandom;
        endcase
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seg_share_arbiter.md
Name: seg_share_arbiter

Overview:
Arbitrates the shared 4-digit seven-segment display between three requesters: result/score, song select and user status. Grants ownership with fixed priority and a minimum hold time so the display does not flicker between owners. Blanks the display for one refresh slot on every ownership change. Drives the multiplexed segment/anode outputs by scanning the owner's 4-character glyph word.

Parameters:
REFRESH_DIV, 200000, clock cycles per digit slot (must be >= 2)
HOLD_MIN, 50000000, minimum cycles an owner keeps the display (must be >= 1)
BLANK_CHAR, 8'b00000000, segment pattern driven while blanked or idle

Ports:
clk  in  1  system clock
reset  in  1  reset; asynchronous, active-high
req  in  3  request per requester; bit0 = score, bit1 = song select, bit2 = user status
glyph0  in  32  requester 0 characters; byte k [8k+7:8k] shown on digit k
glyph1  in  32  requester 1 characters, same layout
glyph2  in  32  requester 2 characters, same layout
grant  out  3  one-hot current owner; 0 when idle
seg  out  8  segment pattern for the active digit
an  out  4  one-hot active-high digit enable
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (asynchronous, immediate, including mid-scan):
  - state = IDLE; grant = 0; seg = BLANK_CHAR; an = 0; busy = 0.
  - Digit index, refresh counter and hold counter cleared.
- States: IDLE, BLANK, OWN. All outputs are registered.
- Priority: req[0] > req[1] > req[2].
- IDLE:
  - an = 0, seg = BLANK_CHAR.
  - On the first cycle with any req high, latch the highest-priority requester as owner, set grant and enter BLANK.
  - grant appears 1 cycle after req.
- BLANK:
  - Lasts exactly REFRESH_DIV cycles with an = 0 and seg = BLANK_CHAR; grant already shows the new owner.
  - Then enter OWN with digit index 0 and the hold counter cleared.
- OWN:
  - Refresh counter runs 0..REFRESH_DIV-1 and wraps; on wrap, digit index increments mod 4 (3 -> 0).
  - an = 1 << digit; seg = owner glyph byte[digit].
  - Glyph is sampled live each cycle, not latched, so score or song changes show without re-arbitration.
- Hold counter:
  - Increments each OWN cycle and saturates at HOLD_MIN.
  - While below HOLD_MIN the owner keeps the display regardless of any req, including its own req dropping.
- Hold expired, evaluated every cycle:
  - Higher-priority req high -> preempt: grant the new owner, enter BLANK.
  - Else owner req low and another req high -> grant the highest remaining requester, enter BLANK.
  - Else owner req low and no req -> IDLE (grant = 0, an = 0 on the next cycle).
  - Else stay in OWN; a lower-priority req never preempts an active owner.
- Switch timing: every owner change passes through exactly one BLANK period; no cycle shows the old owner's digit under the new grant.
- Fixed latencies:
  - From IDLE, first lit digit (an = 4'b0001) appears REFRESH_DIV+1 cycles after req rises.
  - grant is always one-hot or zero.
- req changes during BLANK are ignored until OWN; the arbitration decision is not revisited mid-blank.

Optional Feature:
SEG_ROUND_ROBIN_EN
- Defined:
  - Preemption disabled.
  - When hold has expired and at least one other requester is high (owner req high or low), grant passes to the next requester in circular order after the current owner (0 -> 1 -> 2 -> 0).
  - From IDLE, the search starts after the last owner; after reset, start at requester 0.
  - The owner keeps the display only while no other requester is waiting.
- Undefined: fixed priority and preemption exactly as in Behaviour.

Test Plan (REFRESH_DIV=4, HOLD_MIN=20):
- Reset mid-OWN with an=4'b0100 -> same cycle grant=0, an=0, seg=0, busy=0.
- req=3'b010 from IDLE, glyph1=32'h44332211 -> cycle+1 grant=3'b010; an=0 for 4 cycles; then an 0001/0010/0100/1000 with seg 11/22/33/44, each held 4 cycles, repeating.
- Owner 1, req[0] rises at hold=5 -> no change until hold=20; then grant=3'b001, 4 blank cycles, then glyph0 byte0 on an=0001.
- Owner 0, req[1] high, req[0] drops at hold=3 -> owner 0 still shown until hold=20; then grant=3'b010 via BLANK.
- Owner 2 alone drops req after hold expired -> next cycle IDLE, grant=0, an=0; req=3'b111 simultaneously from IDLE -> grant=3'b001.
- SEG_ROUND_ROBIN_EN, req=3'b111 held -> grant sequence 001, 010, 100, 001, each ownership lasting 20 OWN cycles plus 4 blank cycles.
